uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: GAP_CYCLES, 2, idle clk cycles inserted after tx_busy falls before the next grant (0 allowed).
REQ-002 Parameter: BUSY_TIMEOUT, 16, max clk cycles to wait for tx_busy to rise after tx_start (range 1..255).
REQ-003 Port: clk  input  1  system clock; all state on rising edge.
REQ-004 Port: rst  input  1  asynchronous active-low reset; one clock, no other clock or reset.
REQ-005 Port: req0_valid / req1_valid  input  1 each  requester has a byte to send.
REQ-006 Port: req0_data / req1_data  input  8 each  byte to send; held stable while the matching valid is high and until ack.
REQ-007 Port: req0_ack / req1_ack  output  1 each  one-cycle pulse; byte accepted, requester may drop valid or present the next byte.
REQ-008 Port: tx_busy  input  1  busy flag from the shared UART transmitter.
REQ-009 Port: tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 Port: tx_data  output  8  registered byte to the UART transmitter; held until the next grant.
REQ-011 Port: grant  output  2  one-hot owner of the current frame (bit0 = req0); 00 when idle.
REQ-012 Port: arb_busy  output  1  high in every state except IDLE.
REQ-013 Port: tx_err  output  1  one-cycle pulse on BUSY_TIMEOUT expiry.

Function
REQ-014 States: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP; encoding is free.
REQ-015 IDLE: if any valid is high and tx_busy=0 at edge N, then at N+1: state=START, tx_start=1, tx_data=selected byte, matching ack=1, grant set.
REQ-016 IDLE with tx_busy=1: no grant; the block stays in IDLE.
REQ-017 Selection (default): round-robin; a single valid wins; if both are valid, the requester not granted last wins; the last-grant pointer updates on each grant.
REQ-018 START lasts exactly one cycle, then WAIT_BUSY; tx_start and ack are never high for more than one cycle.
REQ-019 WAIT_BUSY: tx_busy=1 moves to WAIT_DONE; otherwise an 8-bit counter increments; on count = BUSY_TIMEOUT, tx_err pulses one cycle and the next state is GAP.
REQ-020 WAIT_DONE: stays while tx_busy=1; tx_busy=0 moves to GAP, or to IDLE if GAP_CYCLES=0.
REQ-021 GAP: counts GAP_CYCLES cycles, then moves to IDLE; grant clears on entry to IDLE.
REQ-022 Latency: byte-to-byte spacing from tx_busy falling to the next tx_start is GAP_CYCLES+2 cycles when a valid is pending.
REQ-023 A valid that drops before ack is ignored with no side effects; a valid rising in a non-IDLE state waits for IDLE.
REQ-024 req_data changes while valid is high are not protected; tx_data captures only on the grant edge.
REQ-025 Only one ack pulses per frame; each accepted byte yields exactly one tx_start.

Reset
REQ-026 rst=0 asynchronously forces: state IDLE, tx_start 0, tx_data 8'h00, acks 0, grant 00, arb_busy 0, tx_err 0, counters 0, last-grant pointer = req1 (so req0 wins the first contention).
REQ-027 Reset mid-frame aborts with no ack or tx_start after release; the first grant is possible on the second edge after rst rises.

Configuration
REQ-028 Macro UART_ARB_FIXED_PRIO_EN: when defined, req0 always wins over req1 and the last-grant pointer is absent; when undefined, REQ-017 round-robin applies.

Verification
REQ-029 req0_valid=1, data 8'h41; tx_busy rises 1 cycle after tx_start and is held 20 cycles -> tx_start/req0_ack at N+1, tx_data=8'h41, grant=01, next IDLE after GAP of 2 cycles.
REQ-030 Both valid constantly (req0=8'hAA, req1=8'h55), 4 frames -> tx_data sequence AA,55,AA,55; with UART_ARB_FIXED_PRIO_EN -> AA,AA,AA,AA.
REQ-031 tx_busy held 0 after tx_start -> tx_err pulses exactly 16 cycles after the WAIT_BUSY entry, then GAP, then IDLE; no second ack for that byte.
REQ-032 tx_busy=1 while in IDLE with req1_valid=1 -> no grant until tx_busy=0, then grant=10 on the following edge.
REQ-033 rst pulled low in WAIT_DONE -> all outputs return to their reset values immediately; after release, a pending req0 is granted with tx_start on the second edge.
REQ-034 GAP_CYCLES=0, back-to-back req0 bytes 8'h01, 8'h02 -> tx_start two cycles after each tx_busy fall.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between two byte requesters. The owner is
//   chosen only in IDLE and only while the UART is not busy. Each winner gets
//   one ack pulse and one tx_start pulse. The arbiter then waits for tx_busy
//   to rise. If tx_busy never rises, it times out and flags tx_err. It then
//   waits for tx_busy to fall and inserts GAP_CYCLES idle cycles before it
//   can grant again.
//
//   Build option: define UART_ARB_FIXED_PRIO_EN to make req0 always win.
//   Without it, contention is resolved round-robin.
//
// Parameters
//   GAP_CYCLES    idle cycles after tx_busy falls before the next grant (0 ok)
//   BUSY_TIMEOUT  cycles to wait for tx_busy after tx_start (1..255)
// Ports
//   clk, rst                   clock, asynchronous active-low reset
//   req{0,1}_valid/_data/_ack  requester handshakes (ack = 1-cycle pulse)
//   tx_busy, tx_start, tx_data UART transmitter side
//   grant                      one-hot owner of the current frame, 00 when idle
//   arb_busy                   high whenever the FSM is not in IDLE
//   tx_err                     1-cycle pulse when tx_busy fails to rise in time
module uart_tx_arbiter #(
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req0_ack,
  output logic       req1_ack,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [1:0] grant,
  output logic       arb_busy,
  output logic       tx_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_GAP
  } state_e;

  localparam int unsigned     GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]   GAP_LAST = (GAP_CYCLES == 0) ? '0 : GW'(GAP_CYCLES - 1);
  localparam logic [7:0]      TO_LAST  = 8'(BUSY_TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic        rdy_q;
  logic        tx_start_q, tx_start_d;
  logic [1:0]  ack_q, ack_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [1:0]  grant_q, grant_d;
  logic        err_q, err_d;
  logic        pick1;

`ifdef UART_ARB_FIXED_PRIO_EN
  assign pick1 = ~req0_valid;
`else
  // last_q = 1 means req1 owned the previous frame.
  logic last_q, last_d;
  assign pick1 = req1_valid & (~req0_valid | ~last_q);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    tx_start_d = 1'b0;
    ack_d      = 2'b00;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    err_d      = 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
    last_d     = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        // rdy_q holds off the first grant until one edge after reset release.
        if (rdy_q && (req0_valid || req1_valid) && !tx_busy) begin
          state_d    = S_START;
          tx_start_d = 1'b1;
          ack_d      = pick1 ? 2'b10 : 2'b01;
          grant_d    = pick1 ? 2'b10 : 2'b01;
          tx_data_d  = pick1 ? req1_data : req0_data;
`ifndef UART_ARB_FIXED_PRIO_EN
          last_d     = pick1;
`endif
        end
      end
      S_START: begin
        state_d = S_WAIT_BUSY;
        cnt_d   = '0;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == TO_LAST) begin
            err_d = 1'b1;
            gap_d = '0;
            // A zero gap has no GAP cycle to spend, so go straight home.
            if (GAP_CYCLES == 0) begin
              state_d = S_IDLE;
              grant_d = 2'b00;
            end else begin
              state_d = S_GAP;
            end
          end
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          gap_d = '0;
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
            grant_d = 2'b00;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      gap_q      <= '0;
      rdy_q      <= 1'b0;
      tx_start_q <= 1'b0;
      ack_q      <= 2'b00;
      tx_data_q  <= 8'h00;
      grant_q    <= 2'b00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      rdy_q      <= 1'b1;
      tx_start_q <= tx_start_d;
      ack_q      <= ack_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
    end
  end

`ifndef UART_ARB_FIXED_PRIO_EN
  // Reset points at req1 so req0 wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= 1'b1;
    else      last_q <= last_d;
  end
`endif

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign req0_ack = ack_q[0];
  assign req1_ack = ack_q[1];
  assign grant    = grant_q;
  assign tx_err   = err_q;
  assign arb_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of single-frame vectors, a round-robin
// stream, and hand sequences for timeout, busy-in-idle, mid-frame reset and
// zero-gap spacing. Expected bytes/grants are queued when stimulus is driven
// and popped when tx_start appears.
module tb_uart_tx_arbiter;
  localparam int GAP = 2;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance (GAP_CYCLES = 2)
  logic r0v, r1v, busy;
  logic [7:0] r0d, r1d;
  logic ack0, ack1, start, err, abusy;
  logic [7:0] txd;
  logic [1:0] gnt;
  // zero-gap instance
  logic b_r0v, b_r1v, b_busy;
  logic [7:0] b_r0d, b_r1d;
  logic b_ack0, b_ack1, b_start, b_err, b_abusy;
  logic [7:0] b_txd;
  logic [1:0] b_gnt;

  uart_tx_arbiter #(.GAP_CYCLES(GAP), .BUSY_TIMEOUT(TO)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_data(r0d), .req1_valid(r1v), .req1_data(r1d),
    .req0_ack(ack0), .req1_ack(ack1), .tx_busy(busy), .tx_start(start),
    .tx_data(txd), .grant(gnt), .arb_busy(abusy), .tx_err(err));

  uart_tx_arbiter #(.GAP_CYCLES(0), .BUSY_TIMEOUT(TO)) u_dut_g0 (
    .clk(clk), .rst(rst),
    .req0_valid(b_r0v), .req0_data(b_r0d), .req1_valid(b_r1v), .req1_data(b_r1d),
    .req0_ack(b_ack0), .req1_ack(b_ack1), .tx_busy(b_busy), .tx_start(b_start),
    .tx_data(b_txd), .grant(b_gnt), .arb_busy(b_abusy), .tx_err(b_err));

  typedef struct { logic [7:0] data; logic [1:0] grant; } exp_t;
  typedef struct {
    logic start; logic [1:0] ack; logic [7:0] data; logic [1:0] gnt;
    logic busy; logic err;
  } obs_t;
  typedef struct {
    logic v0; logic v1; logic [7:0] d0; logic [7:0] d1; int hold;
    logic [7:0] ed; logic [1:0] eg;
  } vec_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic obs_t obs(input int s);
    obs_t o;
    if (s == 0) begin
      o.start = start; o.ack = {ack1, ack0}; o.data = txd; o.gnt = gnt;
      o.busy = abusy; o.err = err;
    end else begin
      o.start = b_start; o.ack = {b_ack1, b_ack0}; o.data = b_txd; o.gnt = b_gnt;
      o.busy = b_abusy; o.err = b_err;
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_busy(input int s, input logic v);
    if (s == 0) busy = v; else b_busy = v;
  endtask

  task automatic set_req(input int s, input logic v0, input logic v1,
                         input logic [7:0] d0, input logic [7:0] d1);
    if (s == 0) begin r0v = v0; r1v = v1; r0d = d0; r1d = d1; end
    else begin b_r0v = v0; b_r1v = v1; b_r0d = d0; b_r1d = d1; end
  endtask

  task automatic wait_start(input int s, input int budget, output int n);
    obs_t o;
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      o = obs(s);
      if (o.start) begin n = i; break; end
    end
    if (n < 0) begin
      checks++; errors++;
      $display("FAIL start_timeout: no tx_start within %0d cycles", budget);
    end
  endtask

  // Called in the tx_start cycle: pop the expected frame and compare.
  task automatic sb_check(input string nm, input int s);
    obs_t o;
    exp_t e;
    o = obs(s);
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: tx_start with empty scoreboard, data %0h", nm, o.data);
    end else begin
      e = sb.pop_front();
      chk({nm, " data"}, 32'(o.data), 32'(e.data));
      chk({nm, " grant"}, 32'(o.gnt), 32'(e.grant));
      chk({nm, " ack"}, 32'(o.ack), 32'(e.grant));
    end
  endtask

  // From the tx_start cycle: UART raises busy one cycle later, holds it, then
  // drops it. Returns in the cycle where busy has just gone low.
  task automatic frame_busy(input int s, input int hold);
    obs_t o;
    tick();
    o = obs(s);
    chk("single start/ack pulse", {30'd0, o.start, |o.ack}, 32'd0);
    set_busy(s, 1'b1);
    repeat (hold) tick();
    set_busy(s, 1'b0);
  endtask

  task automatic ticks_to_idle(input int s, output int n);
    obs_t o;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      o = obs(s);
      if (!o.busy) begin n = i; break; end
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " tx_start"}, 32'(start), 32'd0);
    chk({nm, " tx_data"}, 32'(txd), 32'd0);
    chk({nm, " grant"}, 32'(gnt), 32'd0);
    chk({nm, " acks"}, 32'({ack1, ack0}), 32'd0);
    chk({nm, " arb_busy"}, 32'(abusy), 32'd0);
    chk({nm, " tx_err"}, 32'(err), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    chk_reset("reset");
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int n, ackcnt;
    obs_t o;

    vt[0] = '{1'b1, 1'b0, 8'h41, 8'h00, 20, 8'h41, 2'b01};
    vt[1] = '{1'b0, 1'b1, 8'h00, 8'h33, 3,  8'h33, 2'b10};
    vt[2] = '{1'b1, 1'b1, 8'h12, 8'h34, 4,  8'h12, 2'b01};
`ifdef UART_ARB_FIXED_PRIO_EN
    vt[3] = '{1'b1, 1'b1, 8'h56, 8'h78, 2,  8'h56, 2'b01};
`else
    vt[3] = '{1'b1, 1'b1, 8'h56, 8'h78, 2,  8'h78, 2'b10};
`endif
    vt[4] = '{1'b0, 1'b1, 8'h00, 8'h9A, 5,  8'h9A, 2'b10};
    vt[5] = '{1'b1, 1'b1, 8'hBC, 8'hDE, 1,  8'hBC, 2'b01};

    rst = 1'b0;
    set_req(0, 0, 0, 8'h00, 8'h00); set_req(1, 0, 0, 8'h00, 8'h00);
    busy = 1'b0; b_busy = 1'b0;
    do_reset();

    // single-frame vectors
    for (int v = 0; v < 6; v++) begin
      set_req(0, vt[v].v0, vt[v].v1, vt[v].d0, vt[v].d1);
      sb.push_back('{vt[v].ed, vt[v].eg});
      wait_start(0, 8, n);
      chk($sformatf("vec%0d latency", v), 32'(n), 32'd1);
      if (n > 0) sb_check($sformatf("vec%0d", v), 0);
      set_req(0, 0, 0, 8'h00, 8'h00);
      frame_busy(0, vt[v].hold);
      tick();
      chk($sformatf("vec%0d gap grant", v), 32'(gnt), 32'(vt[v].eg));
      ticks_to_idle(0, n);
      chk($sformatf("vec%0d gap len", v), 32'(n + 1), 32'(GAP + 1));
      chk($sformatf("vec%0d idle grant", v), 32'(gnt), 32'd0);
      chk($sformatf("vec%0d held data", v), 32'(txd), 32'(vt[v].ed));
    end

    // stream with both requesters always valid
    do_reset();
    set_req(0, 1, 1, 8'hAA, 8'h55);
    for (int f = 0; f < 4; f++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
      sb.push_back('{8'hAA, 2'b01});
`else
      sb.push_back((f % 2 == 0) ? exp_t'{8'hAA, 2'b01} : exp_t'{8'h55, 2'b10});
`endif
    end
    for (int f = 0; f < 4; f++) begin
      wait_start(0, 12, n);
      chk($sformatf("rr%0d spacing", f), 32'(n), (f == 0) ? 32'd1 : 32'(GAP + 2));
      if (n > 0) sb_check($sformatf("rr%0d", f), 0);
      if (f == 3) set_req(0, 0, 0, 8'h00, 8'h00);
      frame_busy(0, 3);
    end
    ticks_to_idle(0, n);

    // tx_busy never rises: timeout
    set_req(0, 1, 0, 8'h77, 8'h00);
    sb.push_back('{8'h77, 2'b01});
    wait_start(0, 8, n);
    if (n > 0) sb_check("timeout frame", 0);
    set_req(0, 0, 0, 8'h00, 8'h00);
    tick();
    n = -1; ackcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ack0 | ack1 | start) ackcnt++;
      if (err) begin n = i; break; end
    end
    chk("timeout cycles", 32'(n), 32'(TO));
    tick();
    chk("tx_err one pulse", 32'(err), 32'd0);
    chk("timeout in gap", 32'(abusy), 32'd1);
    tick();
    chk("timeout idle", 32'(abusy), 32'd0);
    chk("no extra ack/start", 32'(ackcnt), 32'd0);

    // UART busy while idle: no grant until it clears
    busy = 1'b1;
    set_req(0, 0, 1, 8'h00, 8'h5A);
    sb.push_back('{8'h5A, 2'b10});
    ackcnt = 0;
    repeat (4) begin
      tick();
      if (start | abusy | (gnt != 2'b00)) ackcnt++;
    end
    chk("busy idle hold", 32'(ackcnt), 32'd0);
    busy = 1'b0;
    wait_start(0, 6, n);
    chk("busy release latency", 32'(n), 32'd1);
    if (n > 0) sb_check("busy release", 0);
    set_req(0, 0, 0, 8'h00, 8'h00);
    frame_busy(0, 2);
    ticks_to_idle(0, n);

    // reset during WAIT_DONE
    set_req(0, 1, 0, 8'hC3, 8'h00);
    sb.push_back('{8'hC3, 2'b01});
    wait_start(0, 8, n);
    if (n > 0) sb_check("pre-reset frame", 0);
    r0d = 8'h3C;
    tick();
    busy = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b0;
    busy = 1'b0;
    #1;
    chk_reset("mid-frame reset");
    sb.push_back('{8'h3C, 2'b01});
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_start(0, 6, n);
    chk("post-reset grant edge", 32'(n), 32'd2);
    if (n > 0) sb_check("post-reset frame", 0);
    set_req(0, 0, 0, 8'h00, 8'h00);
    frame_busy(0, 2);
    ticks_to_idle(0, n);

    // zero-gap instance: back-to-back req0 bytes
    set_req(1, 1, 0, 8'h01, 8'h00);
    sb.push_back('{8'h01, 2'b01});
    sb.push_back('{8'h02, 2'b01});
    wait_start(1, 6, n);
    chk("g0 first latency", 32'(n), 32'd1);
    if (n > 0) sb_check("g0 byte1", 1);
    b_r0d = 8'h02;
    frame_busy(1, 3);
    wait_start(1, 6, n);
    chk("g0 spacing", 32'(n), 32'd2);
    if (n > 0) sb_check("g0 byte2", 1);
    set_req(1, 0, 0, 8'h00, 8'h00);
    frame_busy(1, 3);
    ticks_to_idle(1, n);
    chk("g0 idle after fall", 32'(n), 32'd1);
    o = obs(1);
    chk("g0 idle grant", 32'(o.gnt), 32'd0);

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
